// File: rtl/core_defines.sv
// Shared encodings for the core: opcodes, sequencer states and datapath selects.
// The immediate generator and datapath import the same constants.
package core_defines;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_IMM    = 2'b01;
  localparam logic [1:0] PC_SRC_ALU    = 2'b10;

  localparam logic [1:0] ALU_A_RS1    = 2'b00;
  localparam logic [1:0] ALU_A_PC     = 2'b01;
  localparam logic [1:0] ALU_A_ZERO   = 2'b10;
  localparam logic [1:0] ALU_A_PC_OLD = 2'b11;

  localparam logic [1:0] ALU_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b01;
  localparam logic [1:0] ALU_OP_CMP   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_CSR  = 2'b11;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       csr_access;
    logic       illegal_instr;
  } ctrl_t;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE,
      OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_FENCE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Wait-cycle counter for an outstanding memory request; expired flags the
// cycle in which one more unacknowledged wait would reach the limit.
module bus_timeout_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       count_en,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 8'd1;
    end
  end

  // Combinational so the fault lands on the same edge the count would hit the limit.
  assign expired = count_en && (count >= (limit - 8'd1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback sequencing,
// memory handshake, halt at instruction boundaries and bus-timeout fault.
module core_sequencer
  import core_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ack,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       csr_access,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [2:0] state_o
);

  state_t     state_q, state_d, boundary;
  logic [1:0] wb_sel_q, wb_sel_d;
  logic       bus_error_q;
  logic       req, expired, tmo_clear;
  ctrl_t      ctrl, ctrl_out;

  // Memory handshake: mem_rd/mem_wr hold until mem_ack; an ack in the request
  // cycle completes it on that edge, and nothing is requested outside FETCH/MEM.
  assign req       = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign boundary  = halt ? ST_HALTED : ST_FETCH;
  assign tmo_clear = mem_ack || (state_d != state_q);

  bus_timeout_counter u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmo_clear),
    .count_en (req && !mem_ack),
    .limit    (8'(TIMEOUT_CYCLES)),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      wb_sel_q    <= WB_ALU;
      bus_error_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_sel_q <= wb_sel_d;
      if (state_d == ST_FAULT) bus_error_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    wb_sel_d = wb_sel_q;
    ctrl     = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_rd = 1'b1;
        if (mem_ack) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = PC_SRC_PLUS4;
          state_d       = ST_DECODE;
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (is_legal(opcode)) begin
          state_d = ST_EXECUTE;
        end else begin
          ctrl.illegal_instr = 1'b1;
          state_d            = boundary;
        end
      end
      ST_EXECUTE: begin
        wb_sel_d = (opcode == OPC_LOAD)   ? WB_MEM :
                   (opcode == OPC_SYSTEM) ? WB_CSR : WB_ALU;
        case (opcode)
          OPC_OP: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_RS2;
            ctrl.alu_op    = ALU_OP_FUNCT;
            state_d        = ST_WRITEBACK;
          end
          OPC_OP_IMM: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_FUNCT;
            state_d        = ST_WRITEBACK;
          end
          OPC_LUI: begin
            ctrl.alu_src_a = ALU_A_ZERO;
            ctrl.alu_src_b = ALU_B_IMM;
            state_d        = ST_WRITEBACK;
          end
          OPC_AUIPC: begin
            ctrl.alu_src_a = ALU_A_PC_OLD;
            ctrl.alu_src_b = ALU_B_IMM;
            state_d        = ST_WRITEBACK;
          end
          OPC_LOAD, OPC_STORE: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_IMM;
            state_d        = ST_MEM;
          end
          OPC_BRANCH: begin
            ctrl.alu_op = ALU_OP_CMP;
            if (branch_taken) begin
              ctrl.pc_write = 1'b1;
              ctrl.pc_src   = PC_SRC_IMM;
            end
            state_d = boundary;
          end
          OPC_JAL: begin
            // Link value is the already-incremented PC, written on the PC edge.
            ctrl.pc_write  = 1'b1;
            ctrl.pc_src    = PC_SRC_IMM;
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_LINK;
            state_d        = boundary;
          end
          OPC_JALR: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_src    = PC_SRC_ALU;
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_LINK;
            state_d        = boundary;
          end
          OPC_SYSTEM: begin
            ctrl.csr_access = 1'b1;
            state_d         = ST_WRITEBACK;
          end
          default: state_d = boundary;
        endcase
      end
      ST_MEM: begin
        ctrl.mem_addr_sel = 1'b1;
        ctrl.mem_rd       = (opcode == OPC_LOAD);
        ctrl.mem_wr       = (opcode != OPC_LOAD);
        if (mem_ack) begin
          state_d = (opcode == OPC_LOAD) ? ST_WRITEBACK : boundary;
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WRITEBACK: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = wb_sel_q;
        state_d        = boundary;
      end
      ST_HALTED: begin
        if (!halt) state_d = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // Reset silences every output in the same cycle, including in-flight requests.
  assign ctrl_out      = reset ? '0 : ctrl;
  assign mem_rd        = ctrl_out.mem_rd;
  assign mem_wr        = ctrl_out.mem_wr;
  assign mem_addr_sel  = ctrl_out.mem_addr_sel;
  assign ir_write      = ctrl_out.ir_write;
  assign pc_write      = ctrl_out.pc_write;
  assign reg_write     = ctrl_out.reg_write;
  assign pc_src        = ctrl_out.pc_src;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign wb_sel        = ctrl_out.wb_sel;
  assign csr_access    = ctrl_out.csr_access;
  assign illegal_instr = ctrl_out.illegal_instr;
  assign bus_error     = bus_error_q && !reset;
  assign state_o       = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: per-instruction cycle schedules from a phase-level
// reference model, a directed table with latency/pulse counts, and random traffic.
module tb_core_sequencer;

  localparam int TO = 4;
  localparam int W  = 22;

  localparam logic [6:0] L_OP = 7'b0110011, L_IMM = 7'b0010011, L_LUI = 7'b0110111,
                         L_AUIPC = 7'b0010111, L_LD = 7'b0000011, L_ST = 7'b0100011,
                         L_BR = 7'b1100011, L_JAL = 7'b1101111, L_JALR = 7'b1100111,
                         L_SYS = 7'b1110011, L_FENCE = 7'b0001111;

  typedef struct packed {
    logic [2:0] st;
    logic rd, wr, asel, irw, pcw, rw;
    logic [1:0] pcs, a, b, op, wb;
    logic csr, ill, be;
  } vec_t;

  typedef struct packed {
    logic       h;
    logic [6:0] o;
    logic       bt;
    logic       ack;
  } stim_t;

  typedef struct {
    logic [6:0] op;
    logic       bt;
    int         fw, mw;
    logic       h;
    int         lat, rw, pcw, ill, csr;
  } dvec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, halt, branch_taken, mem_ack;
  logic [6:0] opcode;
  logic mem_rd, mem_wr, mem_addr_sel, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic csr_access, illegal_instr, bus_error;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  core_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .halt(halt), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ack(mem_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .wb_sel(wb_sel), .csr_access(csr_access),
    .illegal_instr(illegal_instr), .bus_error(bus_error), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  stim_t        stim_q[$];
  int n_cyc, n_rw, n_pcw, n_ill, n_csr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] act_vec();
    return {state_o, mem_rd, mem_wr, mem_addr_sel, ir_write, pc_write, reg_write,
            pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, csr_access, illegal_instr, bus_error};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic legal(input logic [6:0] o);
    return o inside {L_OP, L_IMM, L_LUI, L_AUIPC, L_LD, L_ST, L_BR, L_JAL, L_JALR, L_SYS, L_FENCE};
  endfunction

  function automatic vec_t vz(input int st);
    vec_t e;
    e = '0;
    e.st = 3'(st);
    return e;
  endfunction

  function automatic logic mid(input bit rnd, input logic hend);
    return rnd ? 1'($urandom) : hend;
  endfunction

  task automatic push(input logic h, input logic [6:0] o, input logic bt, input logic ack, input vec_t e);
    stim_t s;
    s.h = h; s.o = o; s.bt = bt; s.ack = ack;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic add_fault();
    vec_t e;
    for (int k = 0; k < 3; k++) begin
      e = vz(6); e.be = 1'b1;
      push(1'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), e);
    end
  endtask

  task automatic add_halt(input logic hend, input bit rnd);
    int n;
    if (hend) begin
      n = rnd ? $urandom_range(0, 2) : 1;
      for (int k = 0; k < n; k++) push(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), vz(5));
      push(1'b0, 7'($urandom), 1'($urandom), 1'($urandom), vz(5));
    end
  endtask

  // Builds the cycle-by-cycle schedule of one instruction from its phase list.
  task automatic gen_instr(input logic [6:0] op, input logic bt, input int fw, input int mw,
                           input logic hend, input bit rnd, output bit faulted);
    vec_t e;
    bit to_mem, to_wb, is_ld;
    logic [1:0] wbv;
    faulted = 1'b0;
    for (int i = 0; i < fw && i < TO; i++) begin
      e = vz(0); e.rd = 1'b1;
      push(mid(rnd, hend), 7'($urandom), 1'($urandom), 1'b0, e);
    end
    if (fw >= TO) begin add_fault(); faulted = 1'b1; return; end
    e = vz(0); e.rd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    push(mid(rnd, hend), 7'($urandom), 1'($urandom), 1'b1, e);
    e = vz(1);
    if (!legal(op)) begin
      e.ill = 1'b1;
      push(hend, op, 1'($urandom), 1'($urandom), e);
      add_halt(hend, rnd);
      return;
    end
    push(mid(rnd, hend), op, 1'($urandom), 1'($urandom), e);
    e = vz(2); to_mem = 1'b0; to_wb = 1'b0; wbv = 2'b00;
    case (op)
      L_OP:    begin e.op = 2'b01; to_wb = 1'b1; end
      L_IMM:   begin e.b = 2'b01; e.op = 2'b01; to_wb = 1'b1; end
      L_LUI:   begin e.a = 2'b10; e.b = 2'b01; to_wb = 1'b1; end
      L_AUIPC: begin e.a = 2'b11; e.b = 2'b01; to_wb = 1'b1; end
      L_LD:    begin e.b = 2'b01; to_mem = 1'b1; wbv = 2'b01; end
      L_ST:    begin e.b = 2'b01; to_mem = 1'b1; end
      L_BR:    begin e.op = 2'b10; e.pcw = bt; e.pcs = bt ? 2'b01 : 2'b00; end
      L_JAL:   begin e.pcw = 1'b1; e.pcs = 2'b01; e.rw = 1'b1; e.wb = 2'b10; end
      L_JALR:  begin e.b = 2'b01; e.pcw = 1'b1; e.pcs = 2'b10; e.rw = 1'b1; e.wb = 2'b10; end
      L_SYS:   begin e.csr = 1'b1; to_wb = 1'b1; wbv = 2'b11; end
      default: ;
    endcase
    if (!(to_mem || to_wb)) begin
      push(hend, op, (op == L_BR) ? bt : 1'($urandom), 1'($urandom), e);
      add_halt(hend, rnd);
      return;
    end
    push(mid(rnd, hend), op, 1'($urandom), 1'($urandom), e);
    if (to_mem) begin
      is_ld = (op == L_LD);
      for (int i = 0; i < mw && i < TO; i++) begin
        e = vz(3); e.asel = 1'b1; e.rd = is_ld; e.wr = !is_ld;
        push(mid(rnd, hend), op, 1'($urandom), 1'b0, e);
      end
      if (mw >= TO) begin add_fault(); faulted = 1'b1; return; end
      e = vz(3); e.asel = 1'b1; e.rd = is_ld; e.wr = !is_ld;
      push(is_ld ? mid(rnd, hend) : hend, op, 1'($urandom), 1'b1, e);
      if (!is_ld) begin add_halt(hend, rnd); return; end
    end
    e = vz(4); e.rw = 1'b1; e.wb = wbv;
    push(hend, op, 1'($urandom), 1'($urandom), e);
    add_halt(hend, rnd);
  endtask

  // ---------------- drivers ----------------
  task automatic play(input string tag, input int max_n);
    stim_t s;
    logic [W-1:0] e;
    int n;
    n = 0; n_cyc = 0; n_rw = 0; n_pcw = 0; n_ill = 0; n_csr = 0;
    while (stim_q.size() > 0 && (max_n == 0 || n < max_n)) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      halt = s.h; opcode = s.o; branch_taken = s.bt; mem_ack = s.ack;
      #4;
      chk($sformatf("%s cyc%0d outputs", tag, n), 32'(act_vec()), 32'(e));
      if (mem_rd && mem_wr) chk($sformatf("%s cyc%0d rd_wr_excl", tag, n), 32'd1, 32'd0);
      if (state_o != 3'd5) n_cyc++;
      n_rw  += int'(reg_write);
      n_pcw += int'(pc_write);
      n_ill += int'(illegal_instr);
      n_csr += int'(csr_access);
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      halt = 1'($urandom); opcode = 7'($urandom);
      branch_taken = 1'($urandom); mem_ack = 1'($urandom);
      #4;
      chk("reset_outputs_zero", 32'(act_vec()), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  // ---------------- test ----------------
  dvec_t tbl[16];
  logic [6:0] ops[11];

  initial begin
    bit f;
    int r, fw, mw, idx;
    logic [6:0] o;

    tbl[0]  = '{L_IMM,   1'b0, 0, 0, 1'b0, 4, 1, 1, 0, 0};
    tbl[1]  = '{L_LD,    1'b0, 0, 3, 1'b0, 8, 1, 1, 0, 0};
    tbl[2]  = '{L_BR,    1'b1, 0, 0, 1'b0, 3, 0, 2, 0, 0};
    tbl[3]  = '{L_BR,    1'b0, 0, 0, 1'b0, 3, 0, 1, 0, 0};
    tbl[4]  = '{L_JALR,  1'b0, 0, 0, 1'b0, 3, 1, 2, 0, 0};
    tbl[5]  = '{L_OP,    1'b0, 0, 0, 1'b1, 4, 1, 1, 0, 0};
    tbl[6]  = '{7'h00,   1'b0, 0, 0, 1'b0, 2, 0, 1, 1, 0};
    tbl[7]  = '{L_ST,    1'b0, 2, 0, 1'b0, 6, 0, 1, 0, 0};
    tbl[8]  = '{L_SYS,   1'b0, 0, 0, 1'b0, 4, 1, 1, 0, 1};
    tbl[9]  = '{L_JAL,   1'b0, 1, 0, 1'b0, 4, 1, 2, 0, 0};
    tbl[10] = '{L_LUI,   1'b0, 0, 0, 1'b0, 4, 1, 1, 0, 0};
    tbl[11] = '{L_AUIPC, 1'b0, 0, 0, 1'b0, 4, 1, 1, 0, 0};
    tbl[12] = '{L_FENCE, 1'b0, 0, 0, 1'b1, 3, 0, 1, 0, 0};
    tbl[13] = '{L_ST,    1'b0, 0, 3, 1'b0, 7, 0, 1, 0, 0};
    tbl[14] = '{L_LD,    1'b0, 3, 0, 1'b1, 8, 1, 1, 0, 0};
    tbl[15] = '{7'h7f,   1'b0, 0, 0, 1'b1, 2, 0, 1, 1, 0};
    ops = '{L_OP, L_IMM, L_LUI, L_AUIPC, L_LD, L_ST, L_BR, L_JAL, L_JALR, L_SYS, L_FENCE};

    reset = 1'b1; halt = 1'b0; opcode = '0; branch_taken = 1'b0; mem_ack = 1'b0;
    do_reset(2);

    // Directed table: full cycle trace plus DUT-measured latency and pulse counts.
    for (int i = 0; i < 16; i++) begin
      gen_instr(tbl[i].op, tbl[i].bt, tbl[i].fw, tbl[i].mw, tbl[i].h, 1'b0, f);
      play($sformatf("dir%0d", i), 0);
      chk($sformatf("dir%0d latency", i),   32'(n_cyc), 32'(tbl[i].lat));
      chk($sformatf("dir%0d reg_write", i), 32'(n_rw),  32'(tbl[i].rw));
      chk($sformatf("dir%0d pc_write", i),  32'(n_pcw), 32'(tbl[i].pcw));
      chk($sformatf("dir%0d illegal", i),   32'(n_ill), 32'(tbl[i].ill));
      chk($sformatf("dir%0d csr", i),       32'(n_csr), 32'(tbl[i].csr));
    end

    // Fetch timeout, absorbing fault, reset recovery.
    gen_instr(L_IMM, 1'b0, 5, 0, 1'b0, 1'b0, f);
    play("timeout", 0);
    chk("timeout model faulted", 32'(f), 32'd1);
    mem_ack = 1'b1; halt = 1'b0;
    #4;
    chk("fault state held", 32'(state_o), 32'd6);
    chk("fault bus_error", 32'(bus_error), 32'd1);
    chk("fault mem_rd", 32'(mem_rd), 32'd0);
    @(posedge clk); #1;
    do_reset(1);
    mem_ack = 1'b0;
    #4;
    chk("post_reset state", 32'(state_o), 32'd0);
    chk("post_reset mem_rd", 32'(mem_rd), 32'd1);
    chk("post_reset bus_error", 32'(bus_error), 32'd0);
    @(posedge clk); #1;
    gen_instr(L_IMM, 1'b0, 0, 0, 1'b0, 1'b0, f);
    play("recover", 0);
    chk("recover latency", 32'(n_cyc), 32'd4);

    // Reset while a load waits in MEM: request drops at once, no writeback follows.
    gen_instr(L_LD, 1'b0, 0, 2, 1'b0, 1'b0, f);
    play("midreset", 4);
    stim_q.delete(); exp_q.delete();
    do_reset(1);
    mem_ack = 1'b1;
    #4;
    chk("midreset fetch state", 32'(state_o), 32'd0);
    chk("midreset no reg_write", 32'(reg_write), 32'd0);
    chk("midreset mem_rd", 32'(mem_rd), 32'd1);
    @(posedge clk); #1;
    stim_q.delete(); exp_q.delete();
    // Finish the just-fetched instruction as an illegal opcode.
    gen_instr(7'h00, 1'b0, 0, 0, 1'b0, 1'b0, f);
    void'(stim_q.pop_front()); void'(exp_q.pop_front());
    play("midreset_tail", 0);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      idx = $urandom_range(0, 11);
      if (idx == 11) begin
        do o = 7'($urandom); while (legal(o));
      end else begin
        o = ops[idx];
      end
      r  = $urandom_range(0, 19);
      fw = (r == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      r  = $urandom_range(0, 19);
      mw = (r == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      gen_instr(o, 1'($urandom), fw, mw, ($urandom_range(0, 5) == 0), 1'b1, f);
      play($sformatf("rnd%0d", k), 0);
      if (f) do_reset($urandom_range(1, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
